// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage.
//   pipe_state_e  : stage occupancy state (EMPTY / FULL / SKID)
//   CTRL_NOP_FILL : bit replicated across the control width to form the default NOP pattern
//   *_CTRL_W/*_DATA_W : bundle widths of the four MIPS inter-stage registers
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } pipe_state_e;

  // An all-zero control word disables every downstream enable.
  localparam logic CTRL_NOP_FILL = 1'b0;

  localparam int unsigned IF_ID_CTRL_W  = 4;
  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned ID_EX_CTRL_W  = 16;
  localparam int unsigned ID_EX_DATA_W  = 96;
  localparam int unsigned EX_MEM_CTRL_W = 8;
  localparam int unsigned EX_MEM_DATA_W = 72;
  localparam int unsigned MEM_WB_CTRL_W = 4;
  localparam int unsigned MEM_WB_DATA_W = 40;

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage entry (control + data) of the elastic stage.
//   clk_i      : clock
//   reset_i    : synchronous active-high reset, ctrl -> CTRL_NOP, data -> 0
//   clr_ctrl_i : squash, ctrl -> CTRL_NOP, data holds
//   load_i     : capture ctrl_i/data_i
//   ctrl_o/data_o : stored bundles
// Priority: reset > clr_ctrl > load.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int unsigned          CTRL_W   = 16,
  parameter int unsigned          DATA_W   = 96,
  parameter logic [CTRL_W-1:0]    CTRL_NOP = {CTRL_W{CTRL_NOP_FILL}}
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clr_ctrl_i,
  input  logic              load_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctrl_q <= CTRL_NOP;
      data_q <= '0;
    end else if (clr_ctrl_i) begin
      ctrl_q <= CTRL_NOP;
    end else if (load_i) begin
      ctrl_q <= ctrl_i;
      data_q <= data_i;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Generic elastic pipeline register with a two-entry skid buffer.
//   Clk, Reset           : clock, synchronous active-high reset
//   flush                : squash both entries, next state EMPTY
//   in_valid/in_ready    : upstream handshake; in_ctrl/in_data upstream bundles
//   out_valid/out_ready  : downstream handshake; out_ctrl/out_data presented bundles
//   stall_cnt            : saturating count of cycles with out_valid & !out_ready
// in_ready and out_valid decode registered state only, so there is no
// combinational path from out_ready back to in_ready.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W   = 16,
  parameter int unsigned       DATA_W   = 96,
  parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{CTRL_NOP_FILL}},
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic accept, emit;
  logic main_load, main_from_skid, skid_load, clr_ctrl;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_SKID);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    clr_ctrl       = 1'b0;
    if (flush) begin
      // Any accept this cycle is dropped; data entries keep their contents.
      state_d  = ST_EMPTY;
      clr_ctrl = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && emit) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = ST_SKID;
            skid_load = 1'b1;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (emit) begin
            state_d        = ST_FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_in = main_from_skid ? skid_data : in_data;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  pipe_entry_reg #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CTRL_NOP (CTRL_NOP)
  ) u_main (
    .clk_i      (Clk),
    .reset_i    (Reset),
    .clr_ctrl_i (clr_ctrl),
    .load_i     (main_load),
    .ctrl_i     (main_ctrl_in),
    .data_i     (main_data_in),
    .ctrl_o     (main_ctrl),
    .data_o     (main_data)
  );

  pipe_entry_reg #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CTRL_NOP (CTRL_NOP)
  ) u_skid (
    .clk_i      (Clk),
    .reset_i    (Reset),
    .clr_ctrl_i (clr_ctrl),
    .load_i     (skid_load),
    .ctrl_i     (in_ctrl),
    .data_i     (in_data),
    .ctrl_o     (skid_ctrl),
    .data_o     (skid_data)
  );

  // Gate control so downstream enables can never fire on a bubble.
  assign out_ctrl  = out_valid ? main_ctrl : CTRL_NOP;
  assign out_data  = main_data;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- One generic stage register with a valid/ready handshake, a two-entry skid buffer for full throughput under backpressure, and synchronous flush that inserts bubbles.
- Carries a control bus and a data bus separately. The control bus is forced to a NOP pattern whenever the stage holds no valid instruction.
- Adds a saturating stall counter for performance debug.
- Instantiated between each pair of MIPS pipeline stages in place of the hand-written registers.

Parameters:
- CTRL_W, 16, width of the control-signal bundle (ALU op, RF/HI/LO enables, memory controls, etc.)
- DATA_W, 96, width of the data bundle (operands, PC, immediate, destination register, etc.)
- CTRL_NOP, 0, control pattern presented when a slot is empty, flushed or in reset
- CNT_W, 16, width of the stall counter

Ports:
- Clk  in  1  clock, all state changes on its rising edge
- Reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous squash of both entries (branch, jump or exception)
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  stage presents a valid instruction
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control bundle; equals CTRL_NOP when out_valid=0
- out_data  out  DATA_W  data bundle of the main entry; don't-care when out_valid=0
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- Storage: a main entry (main_ctrl, main_data) and a skid entry (skid_ctrl, skid_data).
- State encoding: EMPTY=2'b00, FULL=2'b01, SKID=2'b10.
- Derived outputs:
  - out_valid = (state!=EMPTY)
  - in_ready = (state!=SKID)
  - Both are decoded from registered state only. No combinational path from out_ready to in_ready.
- Transitions, when neither Reset nor flush is asserted:
  - EMPTY: accept -> FULL, main loaded from inputs.
  - FULL: accept&emit -> FULL, main reloaded. accept&!emit -> SKID, skid loaded. !accept&emit -> EMPTY. Otherwise hold.
  - SKID: emit -> FULL, main<=skid. Otherwise hold. in_ready=0, so no accept is possible.
- Latency and throughput:
  - 1 cycle from accept to out_valid when EMPTY.
  - Sustains 1 transfer per cycle with out_ready held high.
  - Order is strictly FIFO.
- Flush:
  - Next state EMPTY. main_ctrl and skid_ctrl <= CTRL_NOP. Data entries hold their values.
  - An input accepted in the flush cycle is discarded.
  - An emit in the flush cycle still counts as delivered downstream.
- Reset has priority over flush:
  - state<=EMPTY, both ctrl<=CTRL_NOP, both data<=0, stall_cnt<=0.
  - Inputs in the reset cycle are ignored.
  - First cycle after reset: out_valid=0, in_ready=1, out_ctrl=CTRL_NOP, out_data=0.
  - Reset mid-operation drops both entries without emitting them.
- out_ctrl = out_valid ? main_ctrl : CTRL_NOP.
  - The gating is redundant with the flush clearing, but required, so downstream enables can never fire on a bubble.
- stall_cnt:
  - +1 on each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by Reset; unaffected by flush.
- Stability: while out_valid=1 and out_ready=0, out_ctrl and out_data must not change.

Decomposition:
- Shared package pipe_pkg holds:
  - state localparams ST_EMPTY, ST_FULL, ST_SKID
  - default CTRL_NOP
  - stage-specific CTRL_W/DATA_W constants for the IF/ID, ID/EX, EX/MEM and MEM/WB instances
- One sub-module, pipe_entry_reg:
  - Parametrised CTRL_W/DATA_W storage entry with load, clear-ctrl and reset inputs.
  - Instantiated twice (main, skid).
  - The FSM and stall counter stay in the top module.

Test Plan:
- Reset, then idle with in_valid=0 -> out_valid=0, in_ready=1, out_ctrl=CTRL_NOP, out_data=0, stall_cnt=0.
- Streaming: 8 beats data=1..8, ctrl=16'h00A1, out_ready=1 continuously -> out_data 1..8 on consecutive cycles, each one cycle after input; in_ready stays 1.
- Backpressure: send 1,2,3 with out_ready=0 from cycle 2 -> state SKID after beat 2 and in_ready=0. Raise out_ready after 4 stall cycles -> outputs 1,2,3 in order, nothing lost or duplicated, stall_cnt=4.
- Flush in SKID state with in_valid=1, data=9 -> next cycle out_valid=0, out_ctrl=CTRL_NOP, in_ready=1; data 9 never appears; stall_cnt unchanged.
- Reset and flush asserted together while FULL -> reset wins: data=0, stall_cnt=0.
- CNT_W=4, out_ready=0 for 20 cycles with a valid entry -> stall_cnt saturates at 15; out_data stable throughout.
